// File: rtl/device_if_pkg.sv
// -----------------------------------------------------------------------------
// device_if_pkg
//
// Shared definitions for the 8-bit CPU bus device interface. Every peripheral
// wrapper (LED PWM, etc.) imports this package so that the bus-side register
// bank and the device logic agree on widths and on the encoding of the bus
// transfer direction.
//
// Contents:
//   DEV_ADDR_W    default bus address width
//   DEV_DATA_W    default register / bus data width
//   DEV_NUM_REGS  default number of byte registers per device
//   dev_byte_t    one register / bus data word
//   dev_mode_e    bus transfer direction (MODE_READ / MODE_WRITE)
// -----------------------------------------------------------------------------
package device_if_pkg;

    localparam int DEV_ADDR_W   = 4;
    localparam int DEV_DATA_W   = 8;
    localparam int DEV_NUM_REGS = 16;

    typedef logic [DEV_DATA_W-1:0] dev_byte_t;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } dev_mode_e;

endpackage : device_if_pkg

// File: rtl/dev_addr_decode.sv
// -----------------------------------------------------------------------------
// dev_addr_decode
//
// One-hot decoder for the register bank write path. Produces a single set bit
// at position addr when en is high and addr selects an implemented register.
// Addresses at or beyond NUM_REGS match no output bit, so an out-of-range
// access decodes to all zeros without a separate range comparison.
//
// Parameters:
//   ADDR_W    address width
//   NUM_REGS  number of outputs (1..2**ADDR_W)
//
// Ports:
//   addr    in   ADDR_W    address to decode
//   en      in   1         qualifier; all outputs low when 0
//   onehot  out  NUM_REGS  decoded select, at most one bit set
// -----------------------------------------------------------------------------
module dev_addr_decode #(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (addr == ADDR_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule : dev_addr_decode

// File: rtl/device_register_bank.sv
// -----------------------------------------------------------------------------
// device_register_bank
//
// Memory-mapped byte register bank sitting between the 8-bit CPU bus and one
// peripheral. The bus writes and reads registers through address / enable /
// mode; the owning device sees every register in parallel on device_data and
// can react to updates through the one-cycle wr_strobe pulse.
//
// Parameters:
//   NUM_REGS     number of byte registers (1..2**ADDR_W)
//   ADDR_W       bus address width
//   DATA_W       register and bus data width
//   RESET_VALUE  value loaded into every register on reset
//
// Ports:
//   clk          in   1                   system clock, rising edge
//   rst          in   1                   asynchronous, active-high reset
//   address      in   ADDR_W              register select
//   enable       in   1                   bus transaction qualifier
//   mode         in   1                   1 = write, 0 = read
//   data_in      in   DATA_W              write data
//   data_out     out  DATA_W              registered read data (1-cycle latency)
//   device_data  out  DATA_W x NUM_REGS   combinational view of all registers
//   wr_strobe    out  NUM_REGS            one-hot pulse for the register written
// -----------------------------------------------------------------------------
module device_register_bank
    import device_if_pkg::*;
#(
    parameter int                 NUM_REGS    = DEV_NUM_REGS,
    parameter int                 ADDR_W      = DEV_ADDR_W,
    parameter int                 DATA_W      = DEV_DATA_W,
    parameter logic [DATA_W-1:0]  RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic                enable,
    input  logic                mode,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic [DATA_W-1:0]   device_data [NUM_REGS-1:0],
    output logic [NUM_REGS-1:0] wr_strobe
);

    dev_mode_e             mode_e;
    logic                  wr_req;
    logic                  rd_req;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [DATA_W-1:0]     rd_mux;
    logic [DATA_W-1:0]     regs [NUM_REGS-1:0];

    assign mode_e = dev_mode_e'(mode);
    assign wr_req = enable && (mode_e == MODE_WRITE);
    assign rd_req = enable && (mode_e == MODE_READ);

    // ---- request decode (combinational, bus cycle) ----
    dev_addr_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_wr_decode (
        .addr   (address),
        .en     (wr_req),
        .onehot (wr_sel)
    );

    // Out-of-range addresses match no entry and leave the default of zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (address == ADDR_W'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

    // ---- register update (clock edge) ----
    // The read mux samples the pre-edge contents; a read at the edge right
    // after a write therefore already sees the written value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_strobe <= '0;
        end else begin
            wr_strobe <= wr_sel;
        end
    end

    // data_out holds its last read value whenever no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_req) begin
            data_out <= rd_mux;
        end
    end

    // ---- parallel device view (combinational) ----
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            device_data[i] = regs[i];
        end
    end

endmodule : device_register_bank

// File: tb/tb_device_register_bank.sv
module tb_device_register_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  address;
    logic        enable;
    logic        mode;
    logic [7:0]  data_in;

    logic [7:0]  data_out;
    logic [7:0]  dd [15:0];
    logic [15:0] wr_strobe;

    // Second instance: fewer registers than the address space, non-zero reset.
    logic [7:0]  data_out_s;
    logic [7:0]  dd_s [11:0];
    logic [11:0] wr_strobe_s;

    int checks = 0;
    int errors = 0;

    device_register_bank #(
        .NUM_REGS    (16),
        .ADDR_W      (4),
        .DATA_W      (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .enable      (enable),
        .mode        (mode),
        .data_in     (data_in),
        .data_out    (data_out),
        .device_data (dd),
        .wr_strobe   (wr_strobe)
    );

    device_register_bank #(
        .NUM_REGS    (12),
        .ADDR_W      (4),
        .DATA_W      (8),
        .RESET_VALUE (8'h5C)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .enable      (enable),
        .mode        (mode),
        .data_in     (data_in),
        .data_out    (data_out_s),
        .device_data (dd_s),
        .wr_strobe   (wr_strobe_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic md, input logic [3:0] a, input logic [7:0] d);
        enable  = en;
        mode    = md;
        address = a;
        data_in = d;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  v;
        logic [15:0] s16;
        logic [11:0] s12;

        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        #12;
        rst = 1'b0;

        // Put something in the bank, then reset between edges.
        drive(1'b1, 1'b1, 4'd0, 8'h5A);
        step();
        chk("pre_wr_dd0", 32'(dd[0]), 32'h5A);
        chk("pre_wr_strobe", 32'(wr_strobe), 32'h0001);
        drive(1'b1, 1'b0, 4'd0, 8'h00);
        step();
        chk("pre_rd_dout", 32'(data_out), 32'h5A);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) chk($sformatf("rst_dd%0d", i), 32'(dd[i]), 32'h00);
        chk("rst_dout", 32'(data_out), 32'h00);
        chk("rst_strobe", 32'(wr_strobe), 32'h0);
        chk("rst_s_dd0", 32'(dd_s[0]), 32'h5C);
        chk("rst_s_dd11", 32'(dd_s[11]), 32'h5C);
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        rst = 1'b0;

        // Write / readback on address 3.
        drive(1'b1, 1'b1, 4'd3, 8'hA5);
        step();
        chk("wr3_strobe", 32'(wr_strobe), 32'h0008);
        chk("wr3_dd3", 32'(dd[3]), 32'hA5);
        for (int i = 0; i < 16; i++)
            if (i != 3) chk($sformatf("wr3_other%0d", i), 32'(dd[i]), 32'h00);
        drive(1'b1, 1'b0, 4'd3, 8'h00);
        step();
        chk("rd3_dout", 32'(data_out), 32'hA5);
        chk("rd3_strobe", 32'(wr_strobe), 32'h0);
        chk("rd3_dd3", 32'(dd[3]), 32'hA5);

        // Full sweep: write addr*17 everywhere, then read everything back.
        for (int a = 0; a < 16; a++) begin
            v = 8'(a * 17);
            drive(1'b1, 1'b1, 4'(a), v);
            step();
            s16 = 16'(1) << a;
            s12 = (a < 12) ? (12'(1) << a) : 12'h000;
            chk($sformatf("sw_strobe%0d", a), 32'(wr_strobe), 32'(s16));
            chk($sformatf("sw_s_strobe%0d", a), 32'(wr_strobe_s), 32'(s12));
        end
        for (int a = 0; a < 16; a++) begin
            v = 8'(a * 17);
            drive(1'b1, 1'b0, 4'(a), 8'h00);
            step();
            chk($sformatf("sr_dout%0d", a), 32'(data_out), 32'(v));
            chk($sformatf("sr_dd%0d", a), 32'(dd[a]), 32'(v));
            chk($sformatf("sr_s_dout%0d", a), 32'(data_out_s), (a < 12) ? 32'(v) : 32'h00);
        end

        // Enable gating: a disabled write must not land or strobe.
        drive(1'b1, 1'b0, 4'd2, 8'h00);
        step();
        chk("gate_pre_dout", 32'(data_out), 32'h22);
        drive(1'b0, 1'b1, 4'd5, 8'hFF);
        step();
        chk("gate_strobe", 32'(wr_strobe), 32'h0);
        chk("gate_dd5", 32'(dd[5]), 32'h55);
        chk("gate_dout", 32'(data_out), 32'h22);
        drive(1'b0, 1'b0, 4'd9, 8'h00);
        step();
        chk("gate_rd_dout", 32'(data_out), 32'h22);

        // Back-to-back writes to address 7, then immediate read.
        drive(1'b1, 1'b1, 4'd7, 8'h11);
        step();
        chk("b2b1_strobe", 32'(wr_strobe), 32'h0080);
        chk("b2b1_dd7", 32'(dd[7]), 32'h11);
        drive(1'b1, 1'b1, 4'd7, 8'h22);
        step();
        chk("b2b2_strobe", 32'(wr_strobe), 32'h0080);
        chk("b2b2_dd7", 32'(dd[7]), 32'h22);
        drive(1'b1, 1'b0, 4'd7, 8'h00);
        step();
        chk("b2b_rd_dout", 32'(data_out), 32'h22);
        chk("b2b_rd_strobe", 32'(wr_strobe), 32'h0);

        // Out-of-range write on the 12-register instance is ignored.
        drive(1'b1, 1'b1, 4'd13, 8'hE7);
        step();
        chk("oor_s_strobe", 32'(wr_strobe_s), 32'h000);
        chk("oor_strobe", 32'(wr_strobe), 32'h2000);
        drive(1'b1, 1'b0, 4'd13, 8'h00);
        step();
        chk("oor_s_dout", 32'(data_out_s), 32'h00);
        chk("oor_dout", 32'(data_out), 32'hE7);

        // Reset during activity: write, then reset between edges.
        drive(1'b1, 1'b1, 4'd9, 8'h3C);
        step();
        chk("ra_dd9", 32'(dd[9]), 32'h3C);
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("ra_rst_dd9", 32'(dd[9]), 32'h00);
        chk("ra_rst_dd7", 32'(dd[7]), 32'h00);
        chk("ra_rst_s_dd9", 32'(dd_s[9]), 32'h5C);
        // Reset held across an edge with a write pending: it must not land.
        drive(1'b1, 1'b1, 4'd4, 8'h77);
        step();
        chk("ra_abort_dd4", 32'(dd[4]), 32'h00);
        chk("ra_abort_strobe", 32'(wr_strobe), 32'h0);
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'd9, 8'h00);
        step();
        chk("ra_rd9_dout", 32'(data_out), 32'h00);
        drive(1'b1, 1'b0, 4'd4, 8'h00);
        step();
        chk("ra_rd4_dout", 32'(data_out), 32'h00);
        chk("ra_rd4_s_dout", 32'(data_out_s), 32'h5C);

        drive(1'b0, 1'b0, 4'd0, 8'h00);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_device_register_bank
